// File: rtl/chngy_update_ctrl.sv
// chngy_update_ctrl - control path for the change-in-Y admittance update.
//
// Accepts one line-change record (from-bus i, to-bus j, delta admittance dy)
// and walks its affected Y-matrix entries in the order (i,i)+, (j,j)+, (i,j)-,
// (j,i)-. A shunt change (i == j) touches only (i,i). For each entry it reads Y
// memory, hands the entry and dy to the update datapath, waits for dp_done_i and
// writes the result back.
//
// Build option: define CHNGY_ZERO_SKIP_EN to retire zero-delta records in the
// accept cycle without touching memory or the datapath.
//
// Ports:
//   clock, reset         clock; asynchronous active-high reset
//   chg_valid_i/ready_o  change-record handshake; chg_from_i, chg_to_i, chg_dy_i
//   mem_rd_*             Y memory read strobe/address {row,col}; data 1 cycle later
//   mem_wr_*             Y memory write strobe/address {row,col}/data
//   dp_exec_en_o         datapath execute enable; dp_y1_o/dp_y2_o/dp_sub_o operands
//   dp_result_i/done_i   datapath result and done flag
//   busy_o               record in progress
//   upd_count_o          completed records (wrapping)
//   err_o                sticky datapath-timeout flag
module chngy_update_ctrl #(
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned DW      = 48,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               chg_valid_i,
  output logic               chg_ready_o,
  input  logic [IDX_W-1:0]   chg_from_i,
  input  logic [IDX_W-1:0]   chg_to_i,
  input  logic [DW-1:0]      chg_dy_i,
  output logic               mem_rd_en_o,
  output logic [2*IDX_W-1:0] mem_rd_addr_o,
  input  logic [DW-1:0]      mem_rd_data_i,
  output logic               mem_wr_en_o,
  output logic [2*IDX_W-1:0] mem_wr_addr_o,
  output logic [DW-1:0]      mem_wr_data_o,
  output logic               dp_exec_en_o,
  output logic [DW-1:0]      dp_y1_o,
  output logic [DW-1:0]      dp_y2_o,
  output logic               dp_sub_o,
  input  logic [DW-1:0]      dp_result_i,
  input  logic               dp_done_i,
  output logic               busy_o,
  output logic [15:0]        upd_count_o,
  output logic               err_o
);

  localparam int unsigned AW   = 2 * IDX_W;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

`ifdef CHNGY_ZERO_SKIP_EN
  localparam bit ZeroSkip = 1'b1;
`else
  localparam bit ZeroSkip = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StRd, StWait, StExec, StWb, StNext} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  from_q, from_d;
  logic [IDX_W-1:0]  to_q, to_d;
  logic [DW-1:0]     dy_q, dy_d;
  logic [1:0]        k_q, k_d;
  logic [DW-1:0]     y1_q, y1_d;
  logic [DW-1:0]     y2_q, y2_d;
  logic              sub_q, sub_d;
  logic [DW-1:0]     res_q, res_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;
  logic [AW-1:0]     elem_addr;
  logic              last_elem;

  // Address of element k: diagonal entries first, then the off-diagonal pair.
  always_comb begin
    elem_addr = '0;
    case (k_q)
      2'd0:    elem_addr = {from_q, from_q};
      2'd1:    elem_addr = {to_q, to_q};
      2'd2:    elem_addr = {from_q, to_q};
      default: elem_addr = {to_q, from_q};
    endcase
  end

  // A shunt record only ever has element 0.
  assign last_elem = (from_q == to_q) || (k_q == 2'd3);

  always_comb begin
    state_d = state_q;
    from_d  = from_q;
    to_d    = to_q;
    dy_d    = dy_q;
    k_d     = k_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    sub_d   = sub_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (chg_valid_i) begin
          if (ZeroSkip && (chg_dy_i == '0)) begin
            count_d = count_q + 16'd1;
          end else begin
            from_d  = chg_from_i;
            to_d    = chg_to_i;
            dy_d    = chg_dy_i;
            k_d     = 2'd0;
            state_d = StRd;
          end
        end
      end
      StRd: state_d = StWait;
      StWait: begin
        y1_d    = mem_rd_data_i;
        y2_d    = dy_q;
        sub_d   = k_q[1];
        cnt_d   = '0;
        state_d = StExec;
      end
      StExec: begin
        if (dp_done_i) begin
          res_d   = dp_result_i;
          state_d = StWb;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Datapath hung: drop the rest of the record without writing.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: state_d = StNext;
      StNext: begin
        if (last_elem) begin
          count_d = count_q + 16'd1;
          state_d = StIdle;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = StRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      from_q  <= '0;
      to_q    <= '0;
      dy_q    <= '0;
      k_q     <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      from_q  <= from_d;
      to_q    <= to_d;
      dy_q    <= dy_d;
      k_q     <= k_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from the state so an asynchronous reset clears them at once.
  assign chg_ready_o   = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign mem_rd_en_o   = (state_q == StRd);
  assign mem_rd_addr_o = mem_rd_en_o ? elem_addr : '0;
  assign mem_wr_en_o   = (state_q == StWb);
  assign mem_wr_addr_o = mem_wr_en_o ? elem_addr : '0;
  assign mem_wr_data_o = mem_wr_en_o ? res_q : '0;
  assign dp_exec_en_o  = (state_q == StExec);
  assign dp_y1_o       = y1_q;
  assign dp_y2_o       = y2_q;
  assign dp_sub_o      = sub_q;
  assign upd_count_o   = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_chngy_update_ctrl.sv
// Self-checking bench for chngy_update_ctrl: memory and datapath models,
// a write scoreboard fed by a record-level reference model, random records.
module tb_chngy_update_ctrl;

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned DW      = 48;
  localparam int unsigned TIMEOUT = 64;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             chg_valid = 1'b0;
  logic             chg_ready;
  logic [IDX_W-1:0] chg_from = '0;
  logic [IDX_W-1:0] chg_to = '0;
  logic [DW-1:0]    chg_dy = '0;
  logic             mem_rd_en;
  logic [9:0]       mem_rd_addr;
  logic [DW-1:0]    mem_rd_data = '0;
  logic             mem_wr_en;
  logic [9:0]       mem_wr_addr;
  logic [DW-1:0]    mem_wr_data;
  logic             dp_exec_en;
  logic [DW-1:0]    dp_y1;
  logic [DW-1:0]    dp_y2;
  logic             dp_sub;
  logic [DW-1:0]    dp_result;
  logic             dp_done;
  logic             busy;
  logic [15:0]      upd_count;
  logic             err;

  chngy_update_ctrl #(.IDX_W(IDX_W), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .chg_valid_i   (chg_valid),
    .chg_ready_o   (chg_ready),
    .chg_from_i    (chg_from),
    .chg_to_i      (chg_to),
    .chg_dy_i      (chg_dy),
    .mem_rd_en_o   (mem_rd_en),
    .mem_rd_addr_o (mem_rd_addr),
    .mem_rd_data_i (mem_rd_data),
    .mem_wr_en_o   (mem_wr_en),
    .mem_wr_addr_o (mem_wr_addr),
    .mem_wr_data_o (mem_wr_data),
    .dp_exec_en_o  (dp_exec_en),
    .dp_y1_o       (dp_y1),
    .dp_y2_o       (dp_y2),
    .dp_sub_o      (dp_sub),
    .dp_result_i   (dp_result),
    .dp_done_i     (dp_done),
    .busy_o        (busy),
    .upd_count_o   (upd_count),
    .err_o         (err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Complex add/subtract with independent 24-bit wrap on each half.
  function automatic logic [DW-1:0] cplx(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input bit sub);
    logic [23:0] re, im;
    re = sub ? a[47:24] - b[47:24] : a[47:24] + b[47:24];
    im = sub ? a[23:0] - b[23:0] : a[23:0] + b[23:0];
    return {re, im};
  endfunction

  function automatic logic [DW-1:0] init_val(input int a);
    return {24'(a * 32'h1357 + 32'h0abc), 24'(a * 32'h0f1d)};
  endfunction

  // Memory model: registered read, one cycle latency; junk when not reading.
  logic [DW-1:0] mem [0:1023];
  logic          mem_init = 1'b0;
  logic          pk_en = 1'b0;
  logic [9:0]    pk_addr = '0;
  logic [DW-1:0] pk_data = '0;

  // Datapath model: done after dp_lat enabled cycles (0 = never); random
  // spurious done pulses while disabled.
  int   dp_lat = 3;
  int   exec_cnt = 0;
  logic spur = 1'b0;

  assign dp_result = cplx(dp_y1, dp_y2, dp_sub);
  assign dp_done   = dp_exec_en ? (dp_lat != 0 && exec_cnt == dp_lat - 1) : spur;

  always @(posedge clock) begin
    exec_cnt    <= dp_exec_en ? exec_cnt + 1 : 0;
    spur        <= ($urandom_range(0, 3) == 0);
    mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : DW'({$urandom(), $urandom()});
    if (mem_init) begin
      for (int a = 0; a < 1024; a++) mem[a] <= init_val(a);
    end else if (pk_en) begin
      mem[pk_addr] <= pk_data;
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  // Reference model state and write scoreboard.
  typedef struct packed {
    logic [9:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] ref_mem [0:1023];
  logic [15:0]   ref_count = '0;

  task automatic model_record(input logic [4:0] i, input logic [4:0] j, input logic [DW-1:0] dy,
                              output int n);
    logic [9:0]    a[4];
    logic [DW-1:0] v;
    n = (i == j) ? 1 : 4;
`ifdef CHNGY_ZERO_SKIP_EN
    if (dy == '0) n = 0;
`endif
    a[0] = {i, i};
    a[1] = {j, j};
    a[2] = {i, j};
    a[3] = {j, i};
    for (int k = 0; k < n; k++) begin
      v = cplx(ref_mem[a[k]], dy, k >= 2);
      ref_mem[a[k]] = v;
      exp_q.push_back('{addr: a[k], data: v});
    end
    ref_count++;
  endtask

  // Bus monitor, sampled on the falling edge.
  int   overlap = 0;
  int   rd_cnt = 0;
  int   exec_hi = 0;
  int   exec_rises = 0;
  logic exec_prev = 1'b0;

  initial begin
    wr_t w;
    forever begin
      @(negedge clock);
      if (mem_rd_en && mem_wr_en) overlap++;
      if (mem_rd_en) rd_cnt++;
      if (dp_exec_en) exec_hi++;
      if (dp_exec_en && !exec_prev) exec_rises++;
      exec_prev = dp_exec_en;
      if (mem_wr_en) begin
        if (exp_q.size() == 0) begin
          check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", 64'(mem_wr_addr), 64'(w.addr));
          check("wr_data", 64'(mem_wr_data), 64'(w.data));
        end
      end
    end
  end

  task automatic poke(input logic [9:0] a, input logic [DW-1:0] d);
    pk_addr = a;
    pk_data = d;
    pk_en   = 1'b1;
    @(posedge clock);
    #1 pk_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Present a record and return just after the edge that accepts it.
  task automatic drive_and_accept(input logic [4:0] i, input logic [4:0] j,
                                  input logic [DW-1:0] dy, output int waited);
    chg_from  = i;
    chg_to    = j;
    chg_dy    = dy;
    chg_valid = 1'b1;
    waited    = 0;
    while (!chg_ready && waited < 400) begin
      @(negedge clock);
      waited++;
    end
    if (!chg_ready) check("accept_timeout", 64'(chg_ready), 64'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(output int bc);
    bc = 0;
    @(negedge clock);
    while (busy && bc < 400) begin
      bc++;
      @(negedge clock);
    end
  endtask

  task automatic run_only(input logic [4:0] i, input logic [4:0] j, input logic [DW-1:0] dy,
                          input int lat, input int exp_busy);
    int w, bc;
    dp_lat = lat;
    @(negedge clock);
    drive_and_accept(i, j, dy, w);
    chg_valid = 1'b0;
    wait_done(bc);
    check("busy_cycles", 64'(bc), 64'(exp_busy));
    check("upd_count", 64'(upd_count), 64'(ref_count));
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_record(input logic [4:0] i, input logic [4:0] j, input logic [DW-1:0] dy,
                           input int lat);
    int n;
    model_record(i, j, dy, n);
    run_only(i, j, dy, lat, n * (4 + lat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, bc, n, na, nb, r0, e0, lat;
    logic [4:0] ri, rj;
    logic [DW-1:0] rdy;

    for (int a = 0; a < 1024; a++) ref_mem[a] = init_val(a);
    repeat (3) @(negedge clock);
    check("rst_ready", 64'(chg_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(upd_count), 64'd0);
    check("rst_strobes", 64'({mem_rd_en, mem_wr_en, dp_exec_en, dp_sub}), 64'd0);
    check("rst_addr", 64'({mem_rd_addr, mem_wr_addr}), 64'd0);
    check("rst_data", 64'(mem_wr_data | dp_y1 | dp_y2), 64'd0);
    mem_init = 1'b1;
    @(posedge clock);
    #1 mem_init = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Worked example with literal expectations.
    poke({5'd2, 5'd2}, 48'h001000_000000);
    poke({5'd5, 5'd5}, 48'h002000_000000);
    poke({5'd2, 5'd5}, 48'h000800_000000);
    poke({5'd5, 5'd2}, 48'h000800_000000);
    exp_q.push_back('{addr: {5'd2, 5'd2}, data: 48'h001100_000200});
    exp_q.push_back('{addr: {5'd5, 5'd5}, data: 48'h002100_000200});
    exp_q.push_back('{addr: {5'd2, 5'd5}, data: 48'h000700_FFFE00});
    exp_q.push_back('{addr: {5'd5, 5'd2}, data: 48'h000700_FFFE00});
    ref_mem[{5'd2, 5'd2}] = 48'h001100_000200;
    ref_mem[{5'd5, 5'd5}] = 48'h002100_000200;
    ref_mem[{5'd2, 5'd5}] = 48'h000700_FFFE00;
    ref_mem[{5'd5, 5'd2}] = 48'h000700_FFFE00;
    ref_count++;
    run_only(5'd2, 5'd5, 48'h000100_000200, 3, 4 * 7);

    // Shunt change: one read, one write, busy 4+D.
    r0 = rd_cnt;
    do_record(5'd3, 5'd3, 48'h0000AB_FFF001, 4);
    check("shunt_reads", 64'(rd_cnt - r0), 64'd1);

    // Datapath never finishes: timeout, sticky err, nothing written.
    r0 = rd_cnt;
    e0 = exec_hi;
    dp_lat = 0;
    @(negedge clock);
    drive_and_accept(5'd1, 5'd4, 48'h000001_000001, w);
    chg_valid = 1'b0;
    wait_done(bc);
    check("to_busy", 64'(bc), 64'(2 + TIMEOUT));
    check("to_err", 64'(err), 64'd1);
    check("to_exec_cycles", 64'(exec_hi - e0), 64'(TIMEOUT));
    check("to_reads", 64'(rd_cnt - r0), 64'd1);
    check("to_count", 64'(upd_count), 64'(ref_count));
    do_record(5'd1, 5'd4, 48'h000001_000001, 2);
    check("err_sticky", 64'(err), 64'd1);

    // Back-to-back records with chg_valid held high.
    dp_lat = 2;
    model_record(5'd8, 5'd10, 48'h000010_000020, na);
    @(negedge clock);
    drive_and_accept(5'd8, 5'd10, 48'h000010_000020, w);
    chg_from = 5'd11;
    chg_to   = 5'd11;
    chg_dy   = 48'h123456_654321;
    model_record(5'd11, 5'd11, 48'h123456_654321, nb);
    wait_done(bc);
    check("b2b_first_busy", 64'(bc), 64'(na * 6));
    check("b2b_ready", 64'(chg_ready), 64'd1);
    drive_and_accept(5'd11, 5'd11, 48'h123456_654321, w);
    check("b2b_wait", 64'(w), 64'd0);
    chg_valid = 1'b0;
    wait_done(bc);
    check("b2b_second_busy", 64'(bc), 64'(nb * 6));
    check("b2b_count", 64'(upd_count), 64'(ref_count));

    // Zero delta.
    do_record(5'd7, 5'd9, 48'h0, 2);

    // Random records.
    for (int t = 0; t < 24; t++) begin
      ri  = 5'($urandom_range(0, 31));
      rj  = ($urandom_range(0, 3) == 0) ? ri : 5'($urandom_range(0, 31));
      rdy = ($urandom_range(0, 7) == 0) ? '0 : DW'({$urandom(), $urandom()});
      lat = $urandom_range(1, 5);
      do_record(ri, rj, rdy, lat);
    end

    // Asynchronous reset in the middle of EXEC.
    dp_lat = 0;
    @(negedge clock);
    drive_and_accept(5'd6, 5'd1, 48'h000300_000400, w);
    chg_valid = 1'b0;
    repeat (5) @(negedge clock);
    check("pre_rst_exec", 64'(dp_exec_en), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(chg_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_strobes", 64'({mem_rd_en, mem_wr_en, dp_exec_en, dp_sub}), 64'd0);
    check("mid_rst_err_count", 64'({err, upd_count}), 64'd0);
    check("mid_rst_data", 64'(dp_y1 | dp_y2 | mem_wr_data), 64'd0);
    ref_count = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("post_rst_ready", 64'(chg_ready), 64'd1);
    do_record(5'd6, 5'd1, 48'h000300_000400, 3);

    check("rd_wr_overlap", 64'(overlap), 64'd0);
    check("exec_gap_per_elem", 64'(exec_rises), 64'(rd_cnt));
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chngy_update_ctrl.md
Name: chngy_update_ctrl

Overview:
- Control path for the change-in-Y admittance update: accepts one line-change record at a time and drives the Y-update datapath (updateY_calc).
- Reads the affected Y-matrix entries and feeds each one plus the delta admittance to the datapath.
- Waits for the datapath done flag and writes each result back to Y memory.
- Sits between the change-record reader and the Y memory. It is the producer and consumer of the datapath's yInVal/op_yWriteVal interface.

Parameters:
IDX_W, 5, bus-index width.
DW, 48, complex word width: [47:24] real, [23:0] imag.
TIMEOUT, 64, maximum cycles allowed waiting for dp_done per element.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
chg_valid  in  1  change record available
chg_ready  out  1  controller can accept a record
chg_from  in  IDX_W  from-bus index i
chg_to  in  IDX_W  to-bus index j
chg_dy  in  DW  delta admittance
mem_rd_en  out  1  Y memory read strobe
mem_rd_addr  out  2*IDX_W  read address {row,col}
mem_rd_data  in  DW  read data, valid exactly 1 cycle after mem_rd_en
mem_wr_en  out  1  Y memory write strobe
mem_wr_addr  out  2*IDX_W  write address {row,col}
mem_wr_data  out  DW  write data
dp_exec_en  out  1  datapath execute enable
dp_y1  out  DW  old Y entry to datapath
dp_y2  out  DW  delta admittance to datapath
dp_sub  out  1  0 = add, 1 = subtract
dp_result  in  DW  datapath result, valid when dp_done = 1
dp_done  in  1  datapath done flag
busy  out  1  record in progress
upd_count  out  16  completed records, wraps at 65535 -> 0
err  out  1  sticky datapath-timeout flag

Behaviour:
- Reset (asynchronous, active-high; clock/reset as named): state = IDLE.
  - chg_ready = 1.
  - All strobes, dp_exec_en, dp_sub, busy, err, upd_count = 0.
  - Address and data outputs = 0.
- States: IDLE, RD, WAIT, EXEC, WB, NEXT.
- IDLE:
  - chg_ready = 1.
  - On chg_valid & chg_ready, latch i, j, dy; set element k = 0 and busy = 1; go to RD.
  - chg_ready = 0 in every other state.
- Element sequence:
  - k0 = (i,i) add; k1 = (j,j) add; k2 = (i,j) sub; k3 = (j,i) sub.
  - If i == j (shunt change), only k0 is processed.
- RD: one-cycle mem_rd_en with address of element k -> WAIT.
- WAIT: capture mem_rd_data into dp_y1; dp_y2 = dy; dp_sub per element -> EXEC.
- EXEC:
  - dp_exec_en = 1; dp_y1, dp_y2 and dp_sub held stable.
  - On dp_done = 1: capture dp_result, drop dp_exec_en in the next cycle, go to WB.
  - A cycle counter runs in this state. If it reaches TIMEOUT without dp_done: set err = 1 (sticky until reset), drop dp_exec_en, abandon the remaining elements of the record with no write, go to IDLE. upd_count is not incremented.
- WB: one-cycle mem_wr_en, address = element k, data = captured result -> NEXT.
- NEXT:
  - dp_exec_en stays 0 for this cycle, which guarantees the datapath sees a disable between elements.
  - If more elements remain: k++ and go to RD.
  - Otherwise: upd_count++, busy = 0, go to IDLE.
- Per-element latency: 1 (RD) + 1 (WAIT) + D + 1 (WB) + 1 (NEXT), where D is the number of EXEC cycles up to and including dp_done.
- Timing rules:
  - A record arriving during NEXT of the last element is not accepted until IDLE.
  - mem_rd_en and mem_wr_en are never asserted in the same cycle.
  - dp_done seen outside EXEC is ignored.
- Reset mid-operation: immediate return to IDLE with no write issued; partially updated entries remain as written.

Optional Feature:
- Macro: CHNGY_ZERO_SKIP_EN.
- Defined: a record with chg_dy == 0 is accepted in IDLE and retired in 1 cycle.
  - No memory traffic and no dp_exec_en.
  - upd_count is still incremented.
- Undefined: zero-delta records are processed normally through all elements.

Test Plan:
- Reset asserted mid-EXEC -> all outputs return to reset values asynchronously; no mem_wr_en seen afterward; chg_ready = 1 after release.
- Record i=2, j=5, dy=0x000100_000200; memory entries (2,2)=0x001000_000000, (5,5)=0x002000_000000, (2,5)=(5,2)=0x000800_000000; datapath model with 3-cycle done -> four writes in order:
  - {2,2} = 0x001100_000200 (add)
  - {5,5} = 0x002100_000200 (add)
  - {2,5} = 0x000700_FFFE00 (sub)
  - {5,2} = 0x000700_FFFE00 (sub)
  - upd_count = 1.
- Shunt record i=j=3 -> exactly one read and one write at {3,3}; busy high for 4+D cycles.
- Datapath model never asserts dp_done -> err = 1 after 64 EXEC cycles; no write; upd_count unchanged; next record still processed.
- Back-to-back chg_valid held high with two records -> second accepted only in the IDLE cycle after the first completes; dp_exec_en low for at least 1 cycle between elements.
- With CHNGY_ZERO_SKIP_EN, dy=0 -> no mem_rd_en or mem_wr_en; upd_count +1 in 1 cycle. Without the macro -> 4 writes, each equal to the unchanged entry.
